fsm_result_collector: RTL and testbench



---
 rtl/fsm_result_collector.sv | 148 ++++++++++++++
 tb/tb_fsm_result_collector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_result_collector.sv
// fsm_result_collector
// Reassembles the nibble-serial result beats of the FSM datapath into one N-bit word,
// least-significant beat first, and presents it on a single-entry valid/ready buffer.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset, priority over everything
//   nib_valid  - beat valid (FSM output-valid flag)
//   nib_data   - beat payload, N_width bits
//   word_ready - downstream accepts word_data this cycle
//   err_clr    - clears the sticky frame_err and overflow flags
//   word_valid - word_data holds an unconsumed word
//   word_data  - reassembled word
//   frame_err  - sticky: a frame ended early
//   overflow   - sticky: a completed word was dropped because the buffer was full
//   busy       - a frame is partially collected
//   frame_cnt  - words loaded into the output buffer, wraps at 255
module fsm_result_collector #(
  parameter int unsigned N       = 32,
  parameter int unsigned N_width = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nib_valid,
  input  logic [N_width-1:0] nib_data,
  input  logic               word_ready,
  input  logic               err_clr,
  output logic               word_valid,
  output logic [N-1:0]       word_data,
  output logic               frame_err,
  output logic               overflow,
  output logic               busy,
  output logic [7:0]         frame_cnt
);

  localparam int unsigned BEATS = N / N_width;
  localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   beat_q, beat_d;
  logic [N-1:0]      asm_q, asm_d;
  logic [N-1:0]      word_q, word_d;
  logic              wvalid_q, wvalid_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              complete;
  logic              trunc;
  logic [N-1:0]      done_word;

  // Assembly FSM
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    asm_d     = asm_q;
    complete  = 1'b0;
    trunc     = 1'b0;
    done_word = '0;
    unique case (state_q)
      StIdle: begin
        if (nib_valid) begin
          asm_d = N'(nib_data);
          if (BEATS == 1) begin
            complete  = 1'b1;
            done_word = asm_d;
            asm_d     = '0;
          end else begin
            beat_d  = CntW'(1);
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (nib_valid) begin
          asm_d[int'(beat_q)*N_width +: N_width] = nib_data;
          if (beat_q == CntW'(BEATS - 1)) begin
            complete  = 1'b1;
            done_word = asm_d;
            beat_d    = '0;
            state_d   = StIdle;
          end else begin
            beat_d = beat_q + CntW'(1);
          end
        end else begin
          // Frame ended early: drop the partial word.
          trunc   = 1'b1;
          asm_d   = '0;
          beat_d  = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output buffer and flags; a new error event wins over err_clr.
  always_comb begin
    word_d   = word_q;
    wvalid_d = wvalid_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q & ~err_clr;
    ferr_d   = (ferr_q & ~err_clr) | trunc;
    if (complete) begin
      if (!wvalid_q || word_ready) begin
        word_d   = done_word;
        wvalid_d = 1'b1;
        cnt_d    = cnt_q + 8'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (wvalid_q && word_ready) begin
      wvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      asm_q    <= '0;
      word_q   <= '0;
      wvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      asm_q    <= asm_d;
      word_q   <= word_d;
      wvalid_q <= wvalid_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign word_valid = wvalid_q;
  assign word_data  = word_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q == StCollect);
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_fsm_result_collector.sv
module tb_fsm_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        nib_valid;
  logic [3:0]  nib_data;
  logic        word_ready;
  logic        err_clr;
  logic        word_valid;
  logic [31:0] word_data;
  logic        frame_err;
  logic        overflow;
  logic        busy;
  logic [7:0]  frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fsm_result_collector #(.N(32), .N_width(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .nib_valid (nib_valid),
    .nib_data  (nib_data),
    .word_ready(word_ready),
    .err_clr   (err_clr),
    .word_valid(word_valid),
    .word_data (word_data),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  // One rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Eight beats, LS nibble first; leaves nib_valid low without an extra edge.
  task automatic send_frame(input logic [31:0] w);
    for (int i = 0; i < 8; i++) begin
      nib_valid = 1'b1;
      nib_data  = w[i*4 +: 4];
      step();
    end
    nib_valid = 1'b0;
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      nib_valid = 1'b1;
      nib_data  = 4'(i + 1);
      step();
    end
    nib_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; nib_valid = 1'b0; nib_data = '0; word_ready = 1'b0; err_clr = 1'b0;
    #1;

    // 1: reset state, then basic frame with latency 1
    do_reset();
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_data", word_data, 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    word_ready = 1'b1;
    nib_valid = 1'b1; nib_data = 4'd1; step();
    check("t1_busy_mid", 32'(busy), 32'd1);
    check("t1_valid_mid", 32'(word_valid), 32'd0);
    for (int i = 1; i < 8; i++) begin
      nib_data = 4'(i + 1);
      step();
    end
    nib_valid = 1'b0;
    check("t1_valid", 32'(word_valid), 32'd1);
    check("t1_data", word_data, 32'h8765_4321);
    check("t1_cnt", 32'(frame_cnt), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    step();
    check("t1_drain", 32'(word_valid), 32'd0);
    check("t1_hold", word_data, 32'h8765_4321);

    // 2: back-to-back frames into a stalled buffer
    do_reset();
    word_ready = 1'b0;
    send_frame(32'h1111_1111);
    send_frame(32'h2222_2222);
    check("t2_data", word_data, 32'h1111_1111);
    check("t2_ovf", 32'(overflow), 32'd1);
    check("t2_cnt", 32'(frame_cnt), 32'd1);
    check("t2_valid", 32'(word_valid), 32'd1);
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    check("t2_drain", 32'(word_valid), 32'd0);

    // 3: full buffer but ready on the completing beat -> replace, no overflow
    do_reset();
    word_ready = 1'b0;
    send_frame(32'hAAAA_AAAA);
    check("t3_first", word_data, 32'hAAAA_AAAA);
    for (int i = 0; i < 8; i++) begin
      nib_valid  = 1'b1;
      nib_data   = 4'h5;
      word_ready = (i == 7);
      step();
    end
    nib_valid = 1'b0;
    word_ready = 1'b0;
    check("t3_valid", 32'(word_valid), 32'd1);
    check("t3_data", word_data, 32'h5555_5555);
    check("t3_ovf", 32'(overflow), 32'd0);
    check("t3_cnt", 32'(frame_cnt), 32'd2);

    // 4: truncated frame with a word held, then a good frame
    send_beats(3);
    check("t4_busy_pre", 32'(busy), 32'd1);
    step();
    check("t4_ferr", 32'(frame_err), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_valid", 32'(word_valid), 32'd1);
    check("t4_keep", word_data, 32'h5555_5555);
    word_ready = 1'b1;
    send_frame(32'hDEAD_BEEF);
    check("t4_data", word_data, 32'hDEAD_BEEF);
    check("t4_cnt", 32'(frame_cnt), 32'd3);
    check("t4_ferr_sticky", 32'(frame_err), 32'd1);

    // 5: reset mid-frame
    send_beats(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid", 32'(word_valid), 32'd0);
    check("t5_data", word_data, 32'd0);
    check("t5_ferr", 32'(frame_err), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cnt", 32'(frame_cnt), 32'd0);
    send_frame(32'h0F0F_0F0F);
    check("t5_word", word_data, 32'h0F0F_0F0F);
    check("t5_cnt1", 32'(frame_cnt), 32'd1);
    check("t5_ferr1", 32'(frame_err), 32'd0);

    // 6: set wins over err_clr; plain err_clr clears both flags
    word_ready = 1'b0;
    send_frame(32'h1234_5678);
    check("t6_ovf", 32'(overflow), 32'd1);
    check("t6_stable", word_data, 32'h0F0F_0F0F);
    send_beats(2);
    err_clr = 1'b1;
    step();
    check("t6_ferr_set", 32'(frame_err), 32'd1);
    check("t6_ovf_clr", 32'(overflow), 32'd0);
    step();
    err_clr = 1'b0;
    check("t6_ferr_clr", 32'(frame_err), 32'd0);
    check("t6_ovf_clr2", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
